pipelinemul: RTL and testbench

Pipelined shift-add multiplier that reconstructs a dividend from a divider result: product = quotient × divisor + remainder. It is the inverse companion of the pipelined divider and sits on its output side. Uses include round-trip self-checking and recomputing dividends for downstream datapaths. It is fully pipelined with one stage per quotient bit, accepts one operand set per cycle, and supports ready/valid backpressure on both ends.

---
 rtl/divmul_pkg.sv | 26 ++
 rtl/pipelinemul_mulslice.sv | 32 +++
 rtl/pipelinemul.sv | 79 +++++++
 tb/tb_pipelinemul.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/divmul_pkg.sv
// Shared types for the divider/multiplier pair: the per-stage pipeline word
// and the partial-product helper used by each multiplier slice.
package divmul_pkg;

   localparam int DIVIDENDLEN = 16;
   localparam int DIVISORLEN  = 8;
   localparam int PRODLEN     = DIVIDENDLEN + DIVISORLEN;

   typedef struct packed {
      logic                   valid;
      logic                   err;
      logic [DIVIDENDLEN-1:0] quotient;
      logic [DIVISORLEN-1:0]  divisor;
      logic [PRODLEN-1:0]     acc;
   } stage_t;

   // divisor shifted to the weight of one quotient bit, or zero if that bit is clear
   function automatic logic [PRODLEN-1:0] pp_term(input logic                  q_bit,
                                                  input logic [DIVISORLEN-1:0] d,
                                                  input int                    sh);
      logic [PRODLEN-1:0] w_ext;
      w_ext = PRODLEN'(d);
      return q_bit ? (w_ext << sh) : '0;
   endfunction

endpackage

// File: rtl/pipelinemul_mulslice.sv
// One multiplier pipeline stage: adds the partial product for quotient bit BIT
// and registers the whole stage word when the pipe advances.
module mulslice
   import divmul_pkg::*;
#(
   parameter int BIT = 0
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   i_advance,
   input  stage_t i_stage,
   output stage_t o_stage
);

   stage_t w_next;
   stage_t r_stage;

   always_comb begin
      w_next     = i_stage;
      w_next.acc = i_stage.acc + pp_term(i_stage.quotient[BIT], i_stage.divisor, BIT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_stage <= '0;
      else if (i_advance)
         r_stage <= w_next;
   end

   assign o_stage = r_stage;

endmodule

// File: rtl/pipelinemul.sv
// Pipelined shift-add multiplier: product = quotient*divisor + remainder.
// Optional operand check compiled in with PIPELINEMUL_CHECK_EN.
module pipelinemul #(
   parameter int DIVIDENDLEN = 16,
   parameter int DIVISORLEN  = 8
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DIVIDENDLEN-1:0]            quotient,
   input  logic [DIVISORLEN-1:0]             divisor,
   input  logic [DIVISORLEN-1:0]             remainder,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DIVIDENDLEN+DIVISORLEN-1:0] product,
   output logic                              ovf,
   output logic                              err
);
   import divmul_pkg::*;

   stage_t w_seed;
   stage_t r_seed;
   stage_t w_pipe [DIVIDENDLEN:0];
   stage_t w_last;
   logic   w_advance;
   logic   w_unused;

   // one global enable: the whole pipe freezes only when the output is full and blocked
   assign w_advance = !w_last.valid || out_ready;
   assign in_ready  = w_advance;

   always_comb begin
      w_seed          = '0;
      w_seed.valid    = in_valid;
      w_seed.quotient = quotient;
      w_seed.divisor  = divisor;
      w_seed.acc      = PRODLEN'(remainder);
`ifdef PIPELINEMUL_CHECK_EN
      w_seed.err      = (divisor == '0) || (remainder >= divisor);
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_seed <= '0;
      else if (w_advance)
         r_seed <= w_seed;
   end

   assign w_pipe[0] = r_seed;

   // MSB first, matching the divider's bit order
   for (genvar j = 0; j < DIVIDENDLEN; j++) begin : g_stage
      mulslice #(
         .BIT (DIVIDENDLEN-1-j)
      ) u_slice (
         .clock     (clock),
         .reset_n   (reset_n),
         .i_advance (w_advance),
         .i_stage   (w_pipe[j]),
         .o_stage   (w_pipe[j+1])
      );
   end

   assign w_last    = w_pipe[DIVIDENDLEN];
   assign out_valid = w_last.valid;
   assign product   = w_last.acc;
   assign ovf       = |w_last.acc[PRODLEN-1:DIVIDENDLEN];

`ifdef PIPELINEMUL_CHECK_EN
   assign err      = w_last.err;
   assign w_unused = ^{w_last.quotient, w_last.divisor};
`else
   assign err      = 1'b0;
   assign w_unused = ^{w_last.quotient, w_last.divisor, w_last.err};
`endif

endmodule

// File: tb/tb_pipelinemul.sv
// Directed bench for pipelinemul: latency, edge operands, throughput,
// backpressure, operand check flag and mid-flight reset.
module tb_pipelinemul;

`ifdef PIPELINEMUL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] quotient;
   logic [7:0]  divisor;
   logic [7:0]  remainder;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] product;
   logic        ovf;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [23:0] expq [$];

   pipelinemul #(
      .DIVIDENDLEN (16),
      .DIVISORLEN  (8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // drive one operand set into an empty pipe and check its result and latency
   task automatic single(input string tag, input logic [15:0] q, input logic [7:0] d,
                         input logic [7:0] r, input logic [23:0] ep, input logic eo,
                         input logic ee);
      int lat;
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      quotient  = q;
      divisor   = d;
      remainder = r;
      chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat <= 40) begin
         @(negedge clock);
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd16);
      chk({tag, "_prod"}, 32'(product), 32'(ep));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      chk({tag, "_err"}, 32'(err), 32'(ee));
   endtask

   initial begin
      int sent, rcv, first, last;
      bit ok, stale;
      logic [15:0] q;
      logic [7:0]  d, r;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      quotient  = '0;
      divisor   = '0;
      remainder = '0;
      repeat (2) @(negedge clock);
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_prod", 32'(product), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rel_inrdy", 32'(in_ready), 32'd1);

      single("basic", 16'd1234, 8'd37, 8'd12, 24'h00B266, 1'b0, 1'b0);
      single("allones", 16'hFFFF, 8'hFF, 8'd0, 24'hFEFF01, 1'b1, 1'b0);
      single("remfull", 16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 1'b1, 1'b0);
      single("q0", 16'd0, 8'd200, 8'd55, 24'd55, 1'b0, 1'b0);
      single("errbig", 16'd100, 8'd5, 8'd7, 24'd507, 1'b0, CHK);
      single("errdiv0", 16'd100, 8'd0, 8'd9, 24'd9, 1'b0, CHK);

      // back-to-back random operands at full rate
      sent = 0; rcv = 0; first = -1; last = -1; ok = 1'b1;
      for (int c = 0; c < 80 && rcv < 16; c++) begin
         @(negedge clock);
         if (out_valid) begin
            if (expq.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
            else chk("b2b_prod", 32'(product), 32'(expq.pop_front()));
            rcv++;
            if (first < 0) first = c;
            last = c;
         end
         if (!in_ready) ok = 1'b0;
         if (sent < 16) begin
            q = 16'($urandom_range(0, 65535));
            d = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            in_valid = 1'b1; quotient = q; divisor = d; remainder = r;
            expq.push_back(24'(int'(q) * int'(d) + int'(r)));
            sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("b2b_count", 32'(rcv), 32'd16);
      chk("b2b_span", 32'(last - first), 32'd15);
      chk("b2b_inrdy", 32'(ok), 32'd1);

      // fill the pipe against a blocked consumer
      expq.delete();
      @(negedge clock);
      out_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 40 && in_ready; c++) begin
         q = 16'(1000 + c * 7);
         d = 8'(3 + c);
         r = 8'(c);
         in_valid = 1'b1; quotient = q; divisor = d; remainder = r;
         expq.push_back(24'(int'(q) * int'(d) + int'(r)));
         sent++;
         @(negedge clock);
      end
      // offered while blocked: must be ignored
      in_valid = 1'b1; quotient = 16'hABCD; divisor = 8'h11; remainder = 8'h22;
      chk("bp_filled", 32'(sent), 32'd17);
      for (int k = 0; k < 5; k++) begin
         chk("bp_ovalid", 32'(out_valid), 32'd1);
         chk("bp_inrdy", 32'(in_ready), 32'd0);
         chk("bp_hold", 32'(product), 32'(expq[0]));
         @(negedge clock);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin
            if (expq.size() == 0) chk("bp_dup", 32'd1, 32'd0);
            else chk("bp_drain", 32'(product), 32'(expq.pop_front()));
            rcv++;
         end
         @(negedge clock);
      end
      chk("bp_count", 32'(rcv), 32'd17);

      // reset with results in flight
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1; quotient = 16'(c + 1); divisor = 8'd9; remainder = 8'd1;
         @(negedge clock);
      end
      in_valid = 1'b0;
      for (int c = 0; c < 40 && !out_valid; c++) @(negedge clock);
      chk("rst_pre", 32'(out_valid), 32'd1);
      chk("rst_pre_prod", 32'(product), 32'd10);
      reset_n = 1'b0;
      #1;
      chk("rst_async", 32'(out_valid), 32'd0);
      chk("rst_async_prod", 32'(product), 32'd0);
      @(negedge clock);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clock);
         if (out_valid) stale = 1'b1;
      end
      chk("rst_stale", 32'(stale), 32'd0);
      single("postrst", 16'd300, 8'd20, 8'd3, 24'd6003, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
